// File: rtl/data_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_pkg
// Shared definitions for the data memory controller: FSM state encoding,
// word width, default array depth and the address-fault helper used when
// DMEM_ADDR_CHECK_EN is defined.
// -----------------------------------------------------------------------------
package data_mem_ctrl_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned DEPTH_LOG2_DEF = 10;
    localparam int unsigned CNT_W          = 4;   // holds WAIT_CYCLES-1 for 0..15

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // An address is faulty when it is not word aligned or when any bit above
    // the word index is set.
    function automatic logic addr_fault(input logic [31:0] addr,
                                        input int unsigned depth_log2);
        logic fault;
        fault = (addr[1:0] != 2'b00);
        for (int i = 0; i < 32; i++) begin
            if ((i >= int'(depth_log2 + 2)) && addr[i]) begin
                fault = 1'b1;
            end else begin
                fault = fault;
            end
        end
        return fault;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port synchronous word RAM behind the data memory controller.
// The storage itself has no reset so it maps onto block RAM; only the read
// output register is reset and can be cleared.
//
// Ports:
//   clk    in   clock
//   rst_n  in   async active-low reset (read register only)
//   we     in   write strobe: mem[index] <= wdata
//   re     in   read strobe:  rdata <= mem[index]
//   clr    in   synchronous clear of rdata (takes priority over re)
//   index  in   word index
//   wdata  in   write data
//   rdata  out  registered read data, holds between reads
// -----------------------------------------------------------------------------
module dmem_array
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic                  clr,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [WORD_W-1:0] rdata_q;

    // Array write port (no reset: contents undefined until written).
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[index] <= wdata;
        end
    end

    // Read output register; cleared on reset and on request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {WORD_W{1'b0}};
        end else if (clr) begin
            rdata_q <= {WORD_W{1'b0}};
        end else if (re) begin
            rdata_q <= mem_q[index];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Word-organised data memory with a wait-state access controller. A request
// pulse is accepted in IDLE, the access waits WAIT_CYCLES cycles, and the
// array is written/read on the edge that enters DONE. dmem_ready pulses for
// the single DONE cycle, WAIT_CYCLES+1 cycles after the accepting edge.
//
// Optional feature (macro DMEM_ADDR_CHECK_EN): misaligned or out-of-range
// addresses raise dmem_err with dmem_ready; faulty stores are dropped and
// faulty loads return 0. Without the macro dmem_err is tied 0 and such
// addresses alias onto the word index.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   async active-low reset
//   dmem_req       in   request pulse, ignored while busy
//   dmem_addr      in   byte address
//   dmem_write_en  in   1 = store, 0 = load
//   dmem_val_out   in   store data
//   dmem_val_in    out  last load result
//   dmem_ready     out  access-complete pulse
//   dmem_busy      out  access in progress
//   dmem_err       out  address fault pulse (with dmem_ready)
// -----------------------------------------------------------------------------
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmem_req,
    input  logic [31:0]       dmem_addr,
    input  logic              dmem_write_en,
    input  logic [WORD_W-1:0] dmem_val_out,
    output logic [WORD_W-1:0] dmem_val_in,
    output logic              dmem_ready,
    output logic              dmem_busy,
    output logic              dmem_err
);

    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  we_q, we_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  ready_q;
    logic                  busy_q;
    logic                  accept_s;
    logic                  enter_done_s;
    logic                  fault_s;
    logic                  arr_we_s;
    logic                  arr_re_s;
    logic                  arr_clr_s;

    assign accept_s = (state_q == IDLE) && dmem_req;

    // Next-state logic and holding-register capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (dmem_req) begin
                    idx_d   = dmem_addr[DEPTH_LOG2+1:2];
                    we_d    = dmem_write_en;
                    wdata_d = dmem_val_out;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // DONE is only ever entered from IDLE or WAIT, so this marks the commit edge.
    assign enter_done_s = (state_d == DONE) && (state_q != DONE);

`ifdef DMEM_ADDR_CHECK_EN
    logic fault_q, fault_d;
    logic err_q;

    // Fault flag is evaluated once on the accepted address and then held.
    always_comb begin
        if (accept_s) begin
            fault_d = addr_fault(dmem_addr, DEPTH_LOG2);
        end else begin
            fault_d = fault_q;
        end
    end

    assign fault_s = fault_d;

    // Fault flag holding register and registered error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fault_q <= fault_d;
            err_q   <= enter_done_s && fault_d;
        end
    end

    assign dmem_err = err_q;
`else
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{dmem_addr[31:DEPTH_LOG2+2], dmem_addr[1:0], accept_s};
    assign fault_s  = 1'b0;
    assign dmem_err = 1'b0;
`endif

    // FSM state, wait counter, holding registers and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= {DEPTH_LOG2{1'b0}};
            we_q    <= 1'b0;
            wdata_q <= {WORD_W{1'b0}};
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ready_q <= enter_done_s;
            busy_q  <= (state_d != IDLE);
        end
    end

    // The array sees the "_d" copies so a zero-wait access commits on the
    // accepting edge itself.
    assign arr_we_s  = enter_done_s &&  we_d && !fault_s;
    assign arr_re_s  = enter_done_s && !we_d && !fault_s;
    assign arr_clr_s = enter_done_s && !we_d &&  fault_s;

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_dmem_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we_s),
        .re    (arr_re_s),
        .clr   (arr_clr_s),
        .index (idx_d),
        .wdata (wdata_d),
        .rdata (dmem_val_in)
    );

    assign dmem_ready = ready_q;
    assign dmem_busy  = busy_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed bench for data_mem_ctrl. Three instances share clock and reset:
// unit 0 WAIT_CYCLES=1, unit 1 WAIT_CYCLES=0, unit 2 WAIT_CYCLES=3.
// Address-check expectations follow DMEM_ADDR_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0]       req, we, rdy, bsy, err;
    logic [2:0][31:0] addr, wd, val;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .dmem_req(req[0]), .dmem_addr(addr[0]),
        .dmem_write_en(we[0]), .dmem_val_out(wd[0]), .dmem_val_in(val[0]),
        .dmem_ready(rdy[0]), .dmem_busy(bsy[0]), .dmem_err(err[0]));

    data_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .dmem_req(req[1]), .dmem_addr(addr[1]),
        .dmem_write_en(we[1]), .dmem_val_out(wd[1]), .dmem_val_in(val[1]),
        .dmem_ready(rdy[1]), .dmem_busy(bsy[1]), .dmem_err(err[1]));

    data_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .dmem_req(req[2]), .dmem_addr(addr[2]),
        .dmem_write_en(we[2]), .dmem_val_out(wd[2]), .dmem_val_in(val[2]),
        .dmem_ready(rdy[2]), .dmem_busy(bsy[2]), .dmem_err(err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access on unit u; returns latency (edges from the accepting edge to
    // the first sample showing ready), read data and error at ready.
    task automatic access(input int u, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic [31:0] rd, output logic er);
        @(negedge clk);
        req[u] = 1'b1; we[u] = w; addr[u] = a; wd[u] = d;
        @(posedge clk); #1;
        // scramble inputs: only the latched copies may be used
        req[u] = 1'b0; we[u] = ~w; addr[u] = ~a; wd[u] = ~d;
        lat = 1;
        while (!rdy[u] && lat < 20) begin
            check("busy_wait", 32'(bsy[u]), 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        check("ready_seen", 32'(rdy[u]), 32'd1);
        check("busy_done", 32'(bsy[u]), 32'd1);
        rd = val[u];
        er = err[u];
        @(posedge clk); #1;
        check("ready_pulse_end", 32'(rdy[u]), 32'd0);
        check("busy_end", 32'(bsy[u]), 32'd0);
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic [31:0] rd;
        logic        er;

        req = 3'b000; we = 3'b000; addr = '0; wd = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_val", val[0], 32'h0);
        check("rst_ready", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            for (int u = 0; u < 3; u++) begin
                check("idle_ready", 32'(rdy[u]), 32'd0);
                check("idle_busy", 32'(bsy[u]), 32'd0);
                check("idle_val", val[u], 32'h0);
                check("idle_err", 32'(err[u]), 32'd0);
            end
        end

        // WAIT_CYCLES=1 store then load
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
        check("w1_st_lat", 32'(lat), 32'd2);
        check("w1_st_err", 32'(er), 32'd0);
        check("w1_st_val_kept", rd, 32'h0);
        access(0, 1'b0, 32'h10, 32'h0, lat, rd, er);
        check("w1_ld_lat", 32'(lat), 32'd2);
        check("w1_ld_val", rd, 32'hDEADBEEF);

        // WAIT_CYCLES=0
        access(1, 1'b1, 32'h08, 32'h0BADC0DE, lat, rd, er);
        check("w0_st_lat", 32'(lat), 32'd1);
        access(1, 1'b0, 32'h08, 32'h0, lat, rd, er);
        check("w0_ld_lat", 32'(lat), 32'd1);
        check("w0_ld_val", rd, 32'h0BADC0DE);

        // WAIT_CYCLES=3
        access(2, 1'b1, 32'h0C, 32'h5A5A5A5A, lat, rd, er);
        check("w3_st_lat", 32'(lat), 32'd4);
        access(2, 1'b0, 32'h0C, 32'h0, lat, rd, er);
        check("w3_ld_lat", 32'(lat), 32'd4);
        check("w3_ld_val", rd, 32'h5A5A5A5A);

        // request while busy is dropped (held through WAIT and DONE)
        access(0, 1'b1, 32'h24, 32'h11111111, lat, rd, er);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'hAAAA5555;
        @(posedge clk); #1;
        addr[0] = 32'h24; wd[0] = 32'h99999999;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) req[0] = 1'b0;
            pulses += int'(rdy[0]);
        end
        check("busy_drop_pulses", 32'(pulses), 32'd1);
        access(0, 1'b0, 32'h24, 32'h0, lat, rd, er);
        check("busy_drop_mem24", rd, 32'h11111111);
        access(0, 1'b0, 32'h20, 32'h0, lat, rd, er);
        check("busy_first_mem20", rd, 32'hAAAA5555);

        // reset in the middle of a store
        access(0, 1'b1, 32'h40, 32'h0, lat, rd, er);
        check("store_keeps_val", rd, 32'hAAAA5555);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wd[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("midrst_busy", 32'(bsy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_val", val[0], 32'h0);
        check("midrst_busy0", 32'(bsy[0]), 32'd0);
        check("midrst_ready", 32'(rdy[0]), 32'd0);
        check("midrst_err", 32'(err[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_ready_hold", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b0, 32'h40, 32'h0, lat, rd, er);
        check("midrst_not_committed", rd, 32'h0);

        // address checking / aliasing
        access(0, 1'b1, 32'h42, 32'h12345678, lat, rd, er);
        check("mis_st_lat", 32'(lat), 32'd2);
`ifdef DMEM_ADDR_CHECK_EN
        check("mis_st_err", 32'(er), 32'd1);
        access(0, 1'b0, 32'h40, 32'h0, lat, rd, er);
        check("mis_st_suppressed", rd, 32'h0);
        check("ok_ld_err", 32'(er), 32'd0);
        access(0, 1'b0, 32'h10, 32'h0, lat, rd, er);
        check("ok_ld_val", rd, 32'hDEADBEEF);
        access(0, 1'b0, 32'h0010_0000, 32'h0, lat, rd, er);
        check("oor_ld_err", 32'(er), 32'd1);
        check("oor_ld_val", rd, 32'h0);
        check("oor_ld_lat", 32'(lat), 32'd2);
`else
        check("alias_st_err", 32'(er), 32'd0);
        access(0, 1'b0, 32'h40, 32'h0, lat, rd, er);
        check("alias_ld_val", rd, 32'h12345678);
        check("alias_ld_err", 32'(er), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
